io_cell_bank: RTL

- Parametrised N-channel bidirectional pad bank. Successor to the single-channel combinational IO cell model.
- Keeps the per-channel cfg[0] direction select.
- Adds a two-flop input synchroniser, a programmable glitch filter, rising/falling edge detection and sticky per-channel interrupt flags with write-1-to-clear.
- Sits between the SoC GPIO/peripheral mux and the chip pads: simulation model plus a synthesisable core-side datapath.

---
 rtl/io_cell_bank.sv | 100 ++++++++++
 1 files changed

// File: rtl/io_cell_bank.sv
// N-channel bidirectional pad bank: combinational pad drive, two-flop input
// synchroniser, glitch filter, edge detection and sticky write-1-to-clear irq flags.
module io_cell_bank #(
    parameter int N_CH       = 8,
    parameter int CONF_WIDTH = 3,
    parameter int FILT_LEN   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH*CONF_WIDTH-1:0] io_cell_cfg,
    input  logic [N_CH-1:0]            FROM_CORE,
    output logic [N_CH-1:0]            TO_CORE,
    input  logic [N_CH-1:0]            irq_clear,
    output logic [N_CH-1:0]            irq_pending,
    output logic                       irq,
    inout  wire  [N_CH-1:0]            PAD
);

    localparam int CNT_W = (FILT_LEN > 0) ? $clog2(FILT_LEN + 1) : 1;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic in_mode_s;
        logic rise_en_s;
        logic fall_en_s;
        logic s1_r;
        logic s2_r;
        logic filt_s;
        logic prev_r;
        logic set_s;
        logic pend_r;

        assign in_mode_s = io_cell_cfg[i*CONF_WIDTH];
        assign rise_en_s = io_cell_cfg[i*CONF_WIDTH+1];
        assign fall_en_s = io_cell_cfg[i*CONF_WIDTH+2];

        // Pads float during reset so the chip never drives before config is known.
        assign PAD[i] = (!rst && !in_mode_s) ? FROM_CORE[i] : 1'bz;

        // Two-flop synchroniser, held at zero while the channel drives the pad.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_r <= 1'b0;
                s2_r <= 1'b0;
            end else if (!in_mode_s) begin
                s1_r <= 1'b0;
                s2_r <= 1'b0;
            end else begin
                s1_r <= PAD[i];
                s2_r <= s1_r;
            end
        end

        if (FILT_LEN > 0) begin : g_filt
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);
            logic             filt_r;
            logic [CNT_W-1:0] cnt_r;

            // Glitch filter: any return to the current level restarts the count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    filt_r <= 1'b0;
                    cnt_r  <= '0;
                end else if (!in_mode_s) begin
                    filt_r <= 1'b0;
                    cnt_r  <= '0;
                end else if (s2_r == filt_r) begin
                    cnt_r  <= '0;
                end else if (cnt_r == CNT_MAX) begin
                    filt_r <= s2_r;
                    cnt_r  <= '0;
                end else begin
                    cnt_r  <= cnt_r + CNT_W'(1);
                end
            end

            assign filt_s = filt_r;
        end else begin : g_nofilt
            assign filt_s = s2_r;
        end

        assign set_s = (filt_s & ~prev_r & rise_en_s) | (~filt_s & prev_r & fall_en_s);

        // Edge history and sticky flag; a new edge beats a simultaneous clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prev_r <= 1'b0;
                pend_r <= 1'b0;
            end else begin
                prev_r <= in_mode_s ? filt_s : 1'b0;
                pend_r <= (pend_r & ~irq_clear[i]) | (set_s & in_mode_s);
            end
        end

        assign TO_CORE[i]     = in_mode_s & filt_s;
        assign irq_pending[i] = pend_r;
    end

    assign irq = |irq_pending;

endmodule
